// File: rtl/img_row_loader.sv
// img_row_loader: assembles an H-row binary image from a stream of W-bit rows
// and presents it as one flat vector. An assembly register collects the next
// frame while the output register still holds the frame the classifier is using.
module img_row_loader #(
  parameter int W  = 32,
  parameter int H  = 32,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           row_valid,
  input  logic [W-1:0]   row_data,
  input  logic           row_sof,
  output logic           row_ready,
  output logic [W*H-1:0] img_data,
  output logic           img_valid,
  input  logic           img_ack,
  output logic           frame_err,
  output logic [CW-1:0]  frame_cnt
);

  localparam int CNT_W = (H > 1) ? $clog2(H) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(H - 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W*H-1:0]   asm_q, asm_d;
  logic [W*H-1:0]   img_data_q, img_data_d;
  logic             img_valid_q, img_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [CW-1:0]    frame_cnt_q, frame_cnt_d;

  logic             xfer;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;
  logic             complete;
  logic             slot_free;
  logic             load;

  // Ready depends only on the state, never on row_valid.
  assign row_ready = (state_q != HOLD);
  assign xfer      = row_valid & row_ready;
  assign slot_free = ~img_valid_q | img_ack;

  // Next-state logic: row slot selection, framing errors and frame completion.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (xfer) begin
          if (row_sof) begin
            wr_en   = 1'b1;
            count_d = CNT_W'(1);
            state_d = FILL;
            if (H == 1) complete = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (xfer) begin
          if (row_sof) begin
            // Resync: restart at slot 0; stale slots get overwritten before delivery.
            frame_err_d = 1'b1;
            wr_en       = 1'b1;
            count_d     = CNT_W'(1);
            if (H == 1) complete = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = count_q;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_ROW) complete = 1'b1;
          end
        end
      end
      HOLD: begin
        if (img_ack) begin
          load    = 1'b1;
          count_d = '0;
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
    if (complete) begin
      count_d = '0;
      if (slot_free) begin
        load    = 1'b1;
        state_d = SYNC;
      end else begin
        state_d = HOLD;
      end
    end
  end

  // Assembly register: write the accepted row into its slot (row 0 at the MSBs).
  always_comb begin
    asm_d = asm_q;
    if (wr_en) begin
      for (int r = 0; r < H; r++) begin
        if (wr_idx == CNT_W'(r)) asm_d[W*H-1-W*r -: W] = row_data;
      end
    end
  end

  // Output register: a load beats a simultaneous ack; a bare ack only frees the slot.
  always_comb begin
    img_data_d  = img_data_q;
    img_valid_d = img_valid_q;
    frame_cnt_d = frame_cnt_q;
    if (load) begin
      img_data_d  = asm_d;
      img_valid_d = 1'b1;
      frame_cnt_d = frame_cnt_q + CW'(1);
    end else if (img_ack && img_valid_q) begin
      img_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SYNC;
      count_q     <= '0;
      asm_q       <= '0;
      img_data_q  <= '0;
      img_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      img_data_q  <= img_data_d;
      img_valid_q <= img_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign img_data  = img_data_q;
  assign img_valid = img_valid_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_img_row_loader.sv
// Testbench for img_row_loader: directed scenarios followed by randomized
// traffic, every cycle compared against a frame-level reference model.
module tb_img_row_loader;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           row_valid = 1'b0;
  logic [W-1:0]   row_data = '0;
  logic           row_sof = 1'b0;
  logic           row_ready;
  logic [W*H-1:0] img_data;
  logic           img_valid;
  logic           img_ack = 1'b0;
  logic           frame_err;
  logic [CW-1:0]  frame_cnt;

  img_row_loader #(.W(W), .H(H), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_sof   (row_sof),
    .row_ready (row_ready),
    .img_data  (img_data),
    .img_valid (img_valid),
    .img_ack   (img_ack),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int errs_seen = 0;

  // Reference model: rows of the frame in progress, one pending complete frame,
  // and the frame currently presented at the output.
  logic [W-1:0]   cur[$];
  logic [W*H-1:0] m_pend;
  bit             m_pend_full;
  logic [W*H-1:0] m_img;
  bit             m_valid;
  int             m_cnt;
  bit             m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input logic [W*H-1:0] obs, input logic [W*H-1:0] exp);
    int bad;
    bad = -1;
    for (int r = H - 1; r >= 0; r--) begin
      if (obs[W*H-1-W*r -: W] !== exp[W*H-1-W*r -: W]) bad = r;
    end
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: row %0d observed %h expected %h", tag, bad,
             obs[W*H-1-W*bad -: W], exp[W*H-1-W*bad -: W]);
    end
  endtask

  function automatic logic [W*H-1:0] pack_rows();
    logic [W*H-1:0] f;
    f = '0;
    for (int r = 0; r < H; r++) f[W*H-1-W*r -: W] = cur[r];
    return f;
  endfunction

  task automatic model_reset();
    cur.delete();
    m_pend      = '0;
    m_pend_full = 1'b0;
    m_img       = '0;
    m_valid     = 1'b0;
    m_cnt       = 0;
    m_err       = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    row_valid = 1'b0;
    row_sof   = 1'b0;
    row_data  = '0;
    img_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check outputs.
  task automatic step(input logic v, input logic [W-1:0] d, input logic sof, input logic ack);
    bit ready_exp, xfer, loaded;
    logic [W*H-1:0] f;
    row_valid = v;
    row_data  = d;
    row_sof   = sof;
    img_ack   = ack;
    ready_exp = !m_pend_full;
    chk("row_ready", 64'(row_ready), 64'(ready_exp));
    @(posedge clk);
    #1;
    xfer   = v && ready_exp;
    loaded = 1'b0;
    m_err  = 1'b0;
    if (xfer) begin
      if (sof) begin
        if (cur.size() > 0) m_err = 1'b1;
        cur.delete();
        cur.push_back(d);
      end else if (cur.size() == 0) begin
        m_err = 1'b1;
      end else begin
        cur.push_back(d);
      end
      if (cur.size() == H) begin
        f = pack_rows();
        cur.delete();
        if (!m_valid || ack) begin
          m_img   = f;
          m_valid = 1'b1;
          m_cnt++;
          loaded  = 1'b1;
        end else begin
          m_pend      = f;
          m_pend_full = 1'b1;
        end
      end
    end else if (m_pend_full && ack) begin
      m_img       = m_pend;
      m_pend_full = 1'b0;
      m_valid     = 1'b1;
      m_cnt++;
      loaded      = 1'b1;
    end
    if (!loaded && ack && m_valid) m_valid = 1'b0;
    if (frame_err === 1'b1) errs_seen++;
    chk("img_valid", 64'(img_valid), 64'(m_valid));
    chk("frame_err", 64'(frame_err), 64'(m_err));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt % 256));
    chk_img("img_data", img_data, m_img);
  endtask

  logic [W-1:0]   rows2[H];
  logic [W*H-1:0] exp_frame;
  logic [W-1:0]   rd;
  logic           rv, rs, ra;

  initial begin
    model_reset();
    do_reset();

    // Reset state
    chk("rst_row_ready", 64'(row_ready), 64'd1);
    chk("rst_img_valid", 64'(img_valid), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk_img("rst_img_data", img_data, '0);

    // Single frame: all-ones top row, ones in column 31 below
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int i = 1; i < H; i++) step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    chk("single_valid", 64'(img_valid), 64'd1);
    chk("single_row0", 64'(img_data[1023:992]), 64'hFFFF_FFFF);
    chk("single_lsb", 64'(img_data[0]), 64'd1);
    chk("single_cnt", 64'(frame_cnt), 64'd1);

    // Backpressure: frame B fills behind an unacked frame A
    step(1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0);
    for (int i = 1; i < H; i++) step(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bp_ready_low", 64'(row_ready), 64'd0);
    chk("bp_still_a", 64'(img_data[1023:992]), 64'hFFFF_FFFF);
    step(1'b0, '0, 1'b0, 1'b1);
    chk_img("bp_frame_b", img_data, {H{32'hAAAA_AAAA}});
    chk("bp_valid", 64'(img_valid), 64'd1);
    chk("bp_cnt", 64'(frame_cnt), 64'd2);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("bp_ack_clears", 64'(img_valid), 64'd0);

    // Mid-frame resync
    do_reset();
    errs_seen = 0;
    step(1'b1, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < H; i++) rows2[i] = $urandom;
    for (int i = 0; i < H; i++) step(1'b1, rows2[i], (i == 0), 1'b0);
    for (int i = 0; i < H; i++) exp_frame[W*H-1-W*i -: W] = rows2[i];
    step(1'b0, '0, 1'b0, 1'b0);
    chk("resync_errs", 64'(errs_seen), 64'd1);
    chk("resync_cnt", 64'(frame_cnt), 64'd1);
    chk_img("resync_frame", img_data, exp_frame);

    // Rows without sof while waiting for a frame start
    do_reset();
    errs_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("nosof_errs", 64'(errs_seen), 64'd3);
    chk("nosof_valid", 64'(img_valid), 64'd0);

    // Ack on the same edge as the last row of the next frame
    for (int i = 0; i < H; i++) step(1'b1, 32'h1234_0000 + 32'(i), (i == 0), 1'b0);
    for (int i = 0; i < H; i++) rows2[i] = $urandom;
    for (int i = 0; i < H; i++) step(1'b1, rows2[i], (i == 0), (i == H - 1));
    for (int i = 0; i < H; i++) exp_frame[W*H-1-W*i -: W] = rows2[i];
    chk("simul_valid", 64'(img_valid), 64'd1);
    chk("simul_cnt", 64'(frame_cnt), 64'd2);
    chk_img("simul_frame", img_data, exp_frame);

    // Asynchronous reset while in HOLD
    for (int i = 0; i < H; i++) step(1'b1, $urandom, (i == 0), 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("hold_ready_low", 64'(row_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(img_valid), 64'd0);
    chk("arst_cnt", 64'(frame_cnt), 64'd0);
    chk("arst_ready", 64'(row_ready), 64'd1);
    chk_img("arst_data", img_data, '0);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = (cur.size() == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0);
      ra = ($urandom_range(0, 2) == 0);
      rd = $urandom;
      step(rv, rd, rs, ra);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/img_row_loader.md
Name: img_row_loader

Overview:
- Upstream neighbour of TrafficSystem. Assembles a W x H binary image from a stream of W-bit pixel rows.
- Presents the completed frame as one flat vector on img_data, which wires directly to TrafficSystem's imgData input.
- Uses a two-slot scheme: an assembly register plus an output register. The next frame can fill while the classifier still holds the current one.
- Replaces the ad-hoc file/$fscanf frame loading path with a synthesizable front end.

Parameters:
- W, 32, pixels per row (row word width)
- H, 32, rows per frame
- CW, 8, width of frame_cnt

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- row_valid  input  1  row_data/row_sof valid this cycle
- row_data  input  W  one pixel row; bit W-1 = leftmost pixel (column 0)
- row_sof  input  1  marks the first row of a frame
- row_ready  output  1  loader accepts a row this cycle; transfer = row_valid & row_ready
- img_data  output  W*H  completed frame; row r at bits [W*H-1-W*r -: W], so pixel (0,0) is the MSB
- img_valid  output  1  img_data holds an unconsumed frame
- img_ack  input  1  consumer takes the frame; honoured only while img_valid=1
- frame_err  output  1  one-cycle pulse on a framing error
- frame_cnt  output  CW  frames delivered to the output register, wraps modulo 2^CW

Behaviour:
- Reset (async, immediate on rst=1):
  - state=SYNC, row count=0, assembly register=0
  - img_data=0, img_valid=0, frame_err=0, frame_cnt=0, row_ready=1
- State SYNC (waiting for start of frame):
  - row_ready=1.
  - Transfer with row_sof=1: row written to row slot 0, count=1, go to FILL.
    - If H=1, treat it as the last row (see "last row" below).
  - Transfer with row_sof=0: row discarded, frame_err pulses next cycle, stay in SYNC.
- State FILL (assembling a frame):
  - row_ready=1.
  - Transfer with row_sof=0: row written to slot count, count++.
  - Transfer with row_sof=1: resync.
    - Partial frame is discarded and frame_err pulses.
    - This row is written to slot 0, count=1, stay in FILL.
    - Assembly slots not yet rewritten hold stale data; they are overwritten before delivery.
  - Last row (transfer when count=H-1, row_sof=0):
    - If the output slot is free (img_valid=0, or img_ack=1 this same cycle), copy the assembly register including this row into img_data on the same edge. img_valid=1 next cycle, frame_cnt++, go to SYNC.
    - Otherwise go to HOLD.
- State HOLD (frame complete, output slot occupied):
  - row_ready=0; row_data is ignored.
  - When img_ack=1: the output slot frees and the assembly frame copies to img_data on the same edge. img_valid stays 1 (new frame), frame_cnt++, go to SYNC.
- Output register:
  - img_ack with img_valid=1 and no simultaneous load clears img_valid next cycle; img_data keeps its last value.
  - img_ack while img_valid=0 is ignored.
  - img_data changes only on a load; it is stable while img_valid=1 until acked.
- Latency: last row accepted at edge N with the slot free -> img_valid=1 and new img_data visible after edge N (1 cycle).
- Throughput: with img_ack held at 1, one frame per H accepted rows, with no bubble cycles.
- Simultaneous events:
  - Load and ack in the same cycle: the load wins and img_valid stays 1.
  - sof on the last-row position: treated as a resync, not a completion.
- frame_err: registered, exactly one cycle per offending transfer; back-to-back errors give back-to-back pulses.
- Reset mid-frame or in HOLD: all state is dropped immediately; the pending frame is lost and no frame_err is raised.
- row_ready is a function of state only; it never depends combinationally on row_valid.

Test Plan:
- Single frame:
  - Stimulus: reset, then 32 rows, with row 0 = 32'hFFFF_FFFF (sof), rows 1..31 = 32'h0000_0001, row_valid continuous.
  - Required: img_valid rises the cycle after the 32nd transfer; img_data[1023:992]=32'hFFFF_FFFF; img_data[0]=1; frame_cnt=1.
- Backpressure:
  - Stimulus: deliver frame A, hold img_ack=0, stream frame B (all rows 32'hAAAA_AAAA).
  - Required: row_ready=0 after B's 32nd row; img_data still equals A.
  - Then assert img_ack for one cycle.
  - Required: img_data=all 0xAA pattern, img_valid stays 1, frame_cnt=2, row_ready=1 next cycle.
- Mid-frame resync:
  - Stimulus: sof row, 10 rows, then a new sof row plus 31 rows.
  - Required: frame_err pulses exactly 1 cycle; one frame delivered, equal to the second sequence; frame_cnt=1.
- Row without sof in SYNC:
  - Stimulus: 3 rows with row_sof=0 after reset.
  - Required: 3 single-cycle frame_err pulses, row_ready=1 throughout, img_valid=0.
- Simultaneous ack and load:
  - Stimulus: img_valid=1, img_ack=1 on the same cycle as the last-row transfer.
  - Required: img_valid stays 1, img_data = new frame, no dropped frame.
- Async reset in HOLD:
  - Stimulus: assert rst between clock edges while in HOLD.
  - Required: img_valid=0, img_data=0, frame_cnt=0, row_ready=1 immediately, before the next edge.
